// File: rtl/fd_cache_pkg.sv
// Shared types and sizes for the FD direct-mapped write-back cache.
// Holds the FSM state enum, the geometry constants, the latched request
// payload (Usertype_FD) and small address split helpers.
package fd_cache_pkg;

  localparam int unsigned LINE_NUM = 4;
  localparam int unsigned INDEX_W  = 2;
  localparam int unsigned TAG_W    = 6;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned ADDR_W   = INDEX_W + TAG_W;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [3:0] {
    IDLE,
    LOOKUP,
    EVICT,
    EVICT_WAIT,
    FILL,
    FILL_WAIT,
    RESP,
    FLUSH_SCAN,
    FLUSH_WAIT,
    FLUSH_DONE
  } fdState_t;

  // Request captured at acceptance; rW uses the port encoding (1=read).
  typedef struct packed {
    logic              rW;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } Usertype_FD;

  function automatic logic [INDEX_W-1:0] addrIndex(input logic [ADDR_W-1:0] a);
    return a[INDEX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] addrTag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:INDEX_W];
  endfunction

endpackage

// File: rtl/fd_cache_array.sv
// Tag/valid/dirty/data storage for the FD cache.
// Ports:
//   clk, rst            : clock, synchronous active-high reset (valid/dirty only)
//   rdIdx               : read port line index
//   rdValid_c..rdData_c : combinational read of the addressed line
//   wrEn, wrIdx, wr*    : write port, whole line written at the rising edge
//   validVec, dirtyVec  : per-line valid/dirty flags (used by the flush scan)
module fd_cache_array
  import fd_cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rdIdx,
  output logic                rdValid_c,
  output logic                rdDirty_c,
  output logic [TAG_W-1:0]    rdTag_c,
  output logic [DATA_W-1:0]   rdData_c,
  input  logic                wrEn,
  input  logic [INDEX_W-1:0]  wrIdx,
  input  logic                wrValid,
  input  logic                wrDirty,
  input  logic [TAG_W-1:0]    wrTag,
  input  logic [DATA_W-1:0]   wrData,
  output logic [LINE_NUM-1:0] validVec,
  output logic [LINE_NUM-1:0] dirtyVec
);

  logic [TAG_W-1:0]  tagMem  [LINE_NUM];
  logic [DATA_W-1:0] dataMem [LINE_NUM];

  // Status bits: the only state that reset has to clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      validVec <= '0;
      dirtyVec <= '0;
    end else if (wrEn) begin
      validVec[wrIdx] <= wrValid;
      dirtyVec[wrIdx] <= wrDirty;
    end
  end

  // Payload storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      tagMem[wrIdx]  <= wrTag;
      dataMem[wrIdx] <= wrData;
    end
  end

  assign rdValid_c = validVec[rdIdx];
  assign rdDirty_c = dirtyVec[rdIdx];
  assign rdTag_c   = tagMem[rdIdx];
  assign rdData_c  = dataMem[rdIdx];

endmodule

// File: rtl/fd_cache.sv
// FD cache: 4-line direct-mapped write-back cache between an FD request
// port and a single-outstanding DRAM bridge.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   req_valid/req_r_wb/req_addr/
//   req_data_w                      : request pulse (accepted while busy=0)
//   resp_valid/resp_data            : completion pulse and read/echoed data
//   busy                            : request or flush in progress
//   flush_valid/flush_done          : write back all dirty lines
//   mem_in_valid/mem_r_wb/mem_addr/
//   mem_data_w                      : bridge request (one-cycle pulse)
//   mem_out_valid/mem_data_r        : bridge completion and read data
//   hit_cnt/miss_cnt                : saturating statistics, present only
//                                     when FD_CACHE_STATS_EN is defined
module fd_cache
  import fd_cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_r_wb,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data_w,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              busy,
  input  logic              flush_valid,
  output logic              flush_done,
  output logic              mem_in_valid,
  output logic              mem_r_wb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_w,
  input  logic              mem_out_valid,
  input  logic [DATA_W-1:0] mem_data_r
`ifdef FD_CACHE_STATS_EN
  ,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
`endif
);

  fdState_t           state;
  Usertype_FD         req;
  logic [INDEX_W-1:0] flushIdx;

  logic [INDEX_W-1:0] rdIdx;
  logic               rdValid_c;
  logic               rdDirty_c;
  logic [TAG_W-1:0]   rdTag_c;
  logic [DATA_W-1:0]  rdData_c;
  logic               wrEn;
  logic [INDEX_W-1:0] wrIdx;
  logic               wrValid;
  logic               wrDirty;
  logic [TAG_W-1:0]   wrTag;
  logic [DATA_W-1:0]  wrData;
  logic [LINE_NUM-1:0] validVec;
  logic [LINE_NUM-1:0] dirtyVec;

  logic               hit;
  logic               victimDirty;
  logic               scanFound;
  logic [INDEX_W-1:0] scanIdx;
  logic               moreDirty;

  fd_cache_array u_array (
    .clk       (clk),
    .rst       (rst),
    .rdIdx     (rdIdx),
    .rdValid_c (rdValid_c),
    .rdDirty_c (rdDirty_c),
    .rdTag_c   (rdTag_c),
    .rdData_c  (rdData_c),
    .wrEn      (wrEn),
    .wrIdx     (wrIdx),
    .wrValid   (wrValid),
    .wrDirty   (wrDirty),
    .wrTag     (wrTag),
    .wrData    (wrData),
    .validVec  (validVec),
    .dirtyVec  (dirtyVec)
  );

  assign hit         = rdValid_c && (rdTag_c == addrTag(req.addr));
  assign victimDirty = rdValid_c && rdDirty_c;

  // The read port follows the flush scan while scanning, else the request line.
  assign rdIdx = (state == FLUSH_SCAN) ? scanIdx : addrIndex(req.addr);

  // Lowest dirty line at or above flushIdx, and whether any dirty line
  // remains above the one currently being written back.
  always_comb begin
    scanFound = 1'b0;
    scanIdx   = '0;
    moreDirty = 1'b0;
    for (int i = LINE_NUM - 1; i >= 0; i--) begin
      if (validVec[i] && dirtyVec[i]) begin
        if (i >= int'(flushIdx)) begin
          scanFound = 1'b1;
          scanIdx   = INDEX_W'(i);
        end
        if (i > int'(addrIndex(mem_addr))) moreDirty = 1'b1;
      end
    end
  end

  // Array write port: line installs, write hits and dirty clears after write-back.
  always_comb begin
    wrEn    = 1'b0;
    wrIdx   = addrIndex(req.addr);
    wrValid = 1'b1;
    wrDirty = 1'b0;
    wrTag   = addrTag(req.addr);
    wrData  = req.data;
    case (state)
      LOOKUP: begin
        // Write hit, or write miss whose victim needs no write-back.
        if (!req.rW && (hit || !victimDirty)) begin
          wrEn    = 1'b1;
          wrDirty = 1'b1;
        end
      end
      EVICT_WAIT: begin
        if (mem_out_valid && !req.rW) begin
          wrEn    = 1'b1;
          wrDirty = 1'b1;
        end
      end
      FILL_WAIT: begin
        if (mem_out_valid) begin
          wrEn   = 1'b1;
          wrData = mem_data_r;
        end
      end
      FLUSH_WAIT: begin
        // Rewrite the flushed line from the bridge registers with dirty cleared.
        if (mem_out_valid) begin
          wrEn   = 1'b1;
          wrIdx  = addrIndex(mem_addr);
          wrTag  = addrTag(mem_addr);
          wrData = mem_data_w;
        end
      end
      default: ;
    endcase
  end

  // Control FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req          <= '0;
      flushIdx     <= '0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      busy         <= 1'b0;
      flush_done   <= 1'b0;
      mem_in_valid <= 1'b0;
      mem_r_wb     <= 1'b1;
      mem_addr     <= '0;
      mem_data_w   <= '0;
    end else begin
      resp_valid   <= 1'b0;
      flush_done   <= 1'b0;
      mem_in_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Flush wins over a simultaneous request, which is dropped.
          if (flush_valid) begin
            flushIdx <= '0;
            busy     <= 1'b1;
            state    <= FLUSH_SCAN;
          end else if (req_valid) begin
            req.rW   <= req_r_wb;
            req.addr <= req_addr;
            req.data <= req_data_w;
            busy     <= 1'b1;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_valid <= 1'b1;
            resp_data  <= req.rW ? rdData_c : req.data;
            state      <= RESP;
          end else if (victimDirty) begin
            mem_in_valid <= 1'b1;
            mem_r_wb     <= 1'b0;
            mem_addr     <= {rdTag_c, addrIndex(req.addr)};
            mem_data_w   <= rdData_c;
            state        <= EVICT;
          end else if (req.rW) begin
            mem_in_valid <= 1'b1;
            mem_r_wb     <= 1'b1;
            mem_addr     <= req.addr;
            state        <= FILL;
          end else begin
            resp_valid <= 1'b1;
            resp_data  <= req.data;
            state      <= RESP;
          end
        end
        EVICT: state <= EVICT_WAIT;
        EVICT_WAIT: begin
          if (mem_out_valid) begin
            if (req.rW) begin
              mem_in_valid <= 1'b1;
              mem_r_wb     <= 1'b1;
              mem_addr     <= req.addr;
              state        <= FILL;
            end else begin
              resp_valid <= 1'b1;
              resp_data  <= req.data;
              state      <= RESP;
            end
          end
        end
        FILL: state <= FILL_WAIT;
        FILL_WAIT: begin
          if (mem_out_valid) begin
            resp_valid <= 1'b1;
            resp_data  <= mem_data_r;
            state      <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        FLUSH_SCAN: begin
          if (scanFound) begin
            mem_in_valid <= 1'b1;
            mem_r_wb     <= 1'b0;
            mem_addr     <= {rdTag_c, scanIdx};
            mem_data_w   <= rdData_c;
            state        <= FLUSH_WAIT;
          end else begin
            flush_done <= 1'b1;
            state      <= FLUSH_DONE;
          end
        end
        FLUSH_WAIT: begin
          // Finishing here directly keeps flush_done one cycle after the last write-back.
          if (mem_out_valid) begin
            if (moreDirty) begin
              flushIdx <= addrIndex(mem_addr) + INDEX_W'(1);
              state    <= FLUSH_SCAN;
            end else begin
              flush_done <= 1'b1;
              state      <= FLUSH_DONE;
            end
          end
        end
        FLUSH_DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FD_CACHE_STATS_EN
  // Hit/miss classification of accepted requests, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fd_cache.sv
// Self-checking bench for fd_cache: behavioural cache/DRAM model, a
// randomly delayed bridge, directed scenarios and a random request mix.
module tb_fd_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_r_wb;
  logic [7:0]  req_addr;
  logic [63:0] req_data_w;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        busy;
  logic        flush_valid;
  logic        flush_done;
  logic        mem_in_valid;
  logic        mem_r_wb;
  logic [7:0]  mem_addr;
  logic [63:0] mem_data_w;
  logic        mem_out_valid;
  logic [63:0] mem_data_r;
`ifdef FD_CACHE_STATS_EN
  logic [15:0] hitCnt;
  logic [15:0] missCnt;
`endif

  fd_cache dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_r_wb      (req_r_wb),
    .req_addr      (req_addr),
    .req_data_w    (req_data_w),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .busy          (busy),
    .flush_valid   (flush_valid),
    .flush_done    (flush_done),
    .mem_in_valid  (mem_in_valid),
    .mem_r_wb      (mem_r_wb),
    .mem_addr      (mem_addr),
    .mem_data_w    (mem_data_w),
    .mem_out_valid (mem_out_valid),
    .mem_data_r    (mem_data_r)
`ifdef FD_CACHE_STATS_EN
    ,
    .hit_cnt       (hitCnt),
    .miss_cnt      (missCnt)
`endif
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled just after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- bridge model ----------------
  typedef struct packed {
    logic        rw;
    logic [7:0]  addr;
    logic [63:0] data;
  } memTxn_t;

  memTxn_t     memLog[$];
  logic [63:0] dram [256];
  int          pendCnt = 0;
  logic [63:0] pendData;
  int          overlap = 0;
  bit          slowMem = 0;

  initial begin
    mem_out_valid = 1'b0;
    mem_data_r    = '0;
    forever begin
      @(negedge clk);
      mem_out_valid = 1'b0;
      if (pendCnt > 0) begin
        pendCnt--;
        if (pendCnt == 0) begin
          mem_out_valid = 1'b1;
          mem_data_r    = pendData;
        end
      end
      if (mem_in_valid === 1'b1) begin
        memLog.push_back('{mem_r_wb, mem_addr, mem_data_w});
        if (pendCnt != 0) overlap++;
        if (!mem_r_wb) dram[mem_addr] = mem_data_w;
        pendData = dram[mem_addr];
        pendCnt  = slowMem ? 3 : int'($urandom_range(1, 3));
      end
    end
  end

  int respSeen = 0;
  always @(negedge clk) if (resp_valid === 1'b1) respSeen++;

  // ---------------- reference model ----------------
  bit          mValid [4];
  bit          mDirty [4];
  logic [7:0]  mAddr  [4];
  logic [63:0] mData  [4];
  logic [63:0] refMem [256];
  int          mHits = 0;
  int          mMisses = 0;

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      mValid[i] = 0;
      mDirty[i] = 0;
    end
    mHits   = 0;
    mMisses = 0;
  endtask

  task automatic compareLog(input string tag, input memTxn_t exp[$]);
    checkEq({tag, "_mem_cnt"}, 64'(memLog.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < memLog.size(); i++) begin
      checkEq({tag, "_mem_rw"}, 64'(memLog[i].rw), 64'(exp[i].rw));
      checkEq({tag, "_mem_addr"}, 64'(memLog[i].addr), 64'(exp[i].addr));
      if (!exp[i].rw) checkEq({tag, "_mem_wdata"}, memLog[i].data, exp[i].data);
    end
  endtask

  task automatic doReq(input logic rw, input logic [7:0] addr, input logic [63:0] wdata);
    int          idx;
    bit          hit;
    memTxn_t     exp[$];
    logic [63:0] expData;
    int          lat;
    bit          got;
    idx = int'(addr % 8'd4);
    hit = mValid[idx] && (mAddr[idx] == addr);
    if (!hit && mValid[idx] && mDirty[idx]) begin
      exp.push_back('{1'b0, mAddr[idx], mData[idx]});
      refMem[mAddr[idx]] = mData[idx];
    end
    if (hit) mHits++;
    else mMisses++;
    if (rw) begin
      if (!hit) begin
        exp.push_back('{1'b1, addr, 64'h0});
        mData[idx]  = refMem[addr];
        mDirty[idx] = 0;
      end
      expData = mData[idx];
    end else begin
      mData[idx]  = wdata;
      mDirty[idx] = 1;
      expData     = wdata;
    end
    mValid[idx] = 1;
    mAddr[idx]  = addr;

    memLog.delete();
    req_valid  = 1'b1;
    req_r_wb   = rw;
    req_addr   = addr;
    req_data_w = wdata;
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      tick();
      lat++;
      req_valid  = 1'b0;
      req_data_w = {$urandom(), $urandom()};
      if (lat == 1) checkEq("busy_set", 64'(busy), 64'(1));
      got = (resp_valid === 1'b1);
    end
    checkEq("resp_seen", 64'(got), 64'(1));
    if (got) begin
      checkEq("resp_data", resp_data, expData);
      if (hit) checkEq("hit_latency", 64'(lat), 64'(2));
      compareLog("req", exp);
      tick();
      checkEq("resp_pulse", 64'(resp_valid), 64'(0));
      checkEq("busy_clear", 64'(busy), 64'(0));
      checkEq("resp_hold", resp_data, expData);
    end
  endtask

  task automatic doFlush(input bit withReq);
    memTxn_t exp[$];
    int      lat;
    bit      got;
    bit      prevMov;
    int      respBase;
    for (int i = 0; i < 4; i++) begin
      if (mValid[i] && mDirty[i]) begin
        exp.push_back('{1'b0, mAddr[i], mData[i]});
        refMem[mAddr[i]] = mData[i];
        mDirty[i] = 0;
      end
    end
    memLog.delete();
    respBase    = respSeen;
    flush_valid = 1'b1;
    if (withReq) begin
      req_valid  = 1'b1;
      req_r_wb   = 1'($urandom_range(0, 1));
      req_addr   = 8'($urandom_range(0, 255));
      req_data_w = {$urandom(), $urandom()};
    end
    lat = 0;
    got = 0;
    prevMov = 0;
    while (!got && lat < 200) begin
      prevMov = (mem_out_valid === 1'b1);
      tick();
      lat++;
      flush_valid = 1'b0;
      req_valid   = 1'b0;
      got = (flush_done === 1'b1);
    end
    checkEq("flush_seen", 64'(got), 64'(1));
    if (got) begin
      if (exp.size() == 0) checkEq("flush_latency", 64'(lat), 64'(2));
      else checkEq("flush_after_wb", 64'(prevMov), 64'(1));
      compareLog("flush", exp);
      tick();
      checkEq("flush_pulse", 64'(flush_done), 64'(0));
      checkEq("flush_busy_clear", 64'(busy), 64'(0));
      tick();
      checkEq("flush_no_resp", 64'(respSeen), 64'(respBase));
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    checkEq("rst_resp_valid", 64'(resp_valid), 64'(0));
    checkEq("rst_busy", 64'(busy), 64'(0));
    checkEq("rst_flush_done", 64'(flush_done), 64'(0));
    checkEq("rst_mem_in_valid", 64'(mem_in_valid), 64'(0));
    checkEq("rst_mem_r_wb", 64'(mem_r_wb), 64'(1));
    checkEq("rst_mem_addr", 64'(mem_addr), 64'(0));
    checkEq("rst_mem_data_w", mem_data_w, 64'(0));
    checkEq("rst_resp_data", resp_data, 64'(0));
`ifdef FD_CACHE_STATS_EN
    checkEq("rst_hit_cnt", 64'(hitCnt), 64'(0));
    checkEq("rst_miss_cnt", 64'(missCnt), 64'(0));
`endif
    rst = 1'b0;
    modelReset();
  endtask

  task automatic midFillReset();
    int n;
    int respBase;
    slowMem = 1;
    memLog.delete();
    respBase   = respSeen;
    req_valid  = 1'b1;
    req_r_wb   = 1'b1;
    req_addr   = 8'h20;
    req_data_w = '0;
    n = 0;
    tick();
    req_valid = 1'b0;
    while (mem_in_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkEq("midfill_read_issued", 64'(mem_in_valid), 64'(1));
    tick();
    rst = 1'b1;
    tick();
    checkEq("midfill_busy_after_rst", 64'(busy), 64'(0));
    rst = 1'b0;
    modelReset();
    slowMem = 0;
    repeat (6) tick();
    checkEq("midfill_no_resp", 64'(respSeen), 64'(respBase));
    checkEq("midfill_idle_busy", 64'(busy), 64'(0));
    checkEq("midfill_mem_cnt", 64'(memLog.size()), 64'(1));
    doReq(1'b1, 8'h20, '0);
  endtask

  initial begin
    logic [7:0] a;
    int         r;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_r_wb    = 1'b1;
    req_addr    = '0;
    req_data_w  = '0;
    flush_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dram[i]   = {$urandom(), $urandom()};
      refMem[i] = dram[i];
    end
    dram[8'h05]   = 64'h1122334455667788;
    refMem[8'h05] = 64'h1122334455667788;

    doReset();

    // Cold read then hit on 0x05.
    doReq(1'b1, 8'h05, '0);
    doReq(1'b1, 8'h05, '0);
    // Write 0x09 then conflicting read 0x0D forces eviction and fill.
    doReq(1'b0, 8'h09, 64'hDEAD);
    doReq(1'b1, 8'h0D, '0);
    // Dirty lines 0 and 2, flush twice.
    doReq(1'b0, 8'h00, 64'hA0A0);
    doReq(1'b0, 8'h02, 64'hA2A2);
    doFlush(1'b0);
    doFlush(1'b0);
    // Reset during the fill of 0x20.
    midFillReset();
    // Flush and request together: only the flush runs.
    doReq(1'b0, 8'h13, 64'h1313);
    doFlush(1'b1);

`ifdef FD_CACHE_STATS_EN
    doReset();
    doReq(1'b1, 8'h05, '0);
    doReq(1'b1, 8'h05, '0);
    doReq(1'b0, 8'h05, 64'h55);
    doReq(1'b1, 8'h06, '0);
    doReq(1'b1, 8'h06, '0);
    checkEq("stats_hit_cnt", 64'(hitCnt), 64'(3));
    checkEq("stats_miss_cnt", 64'(missCnt), 64'(2));
`endif

    // Random mix of reads, writes and flushes.
    for (int k = 0; k < 250; k++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) doFlush(1'b0);
      else if (r == 1) doFlush(1'b1);
      else begin
        if ($urandom_range(0, 9) < 7) a = 8'($urandom_range(0, 15));
        else a = 8'($urandom_range(0, 255));
        doReq(1'($urandom_range(0, 1)), a, {$urandom(), $urandom()});
      end
      repeat ($urandom_range(0, 2)) tick();
    end

`ifdef FD_CACHE_STATS_EN
    checkEq("final_hit_cnt", 64'(hitCnt), 64'(mHits));
    checkEq("final_miss_cnt", 64'(missCnt), 64'(mMisses));
`endif
    repeat (5) tick();
    checkEq("bridge_overlap", 64'(overlap), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
